reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits wide, for the Hack datapath. It generalises the single load-enabled register to an addressed array with one write/increment port and two independent read ports. An optional write-through bypass and a per-entry "written" bitmap are included. It backs the A/D/scratch register set and RAM8-style storage without chaining discrete registers.

## Interface
Parameters:
- WIDTH, 16, bits per register.
- DEPTH, 8, number of registers; need not be a power of two (min 2).
- AW, $clog2(DEPTH), address width. Derived only; not to be overridden.
- RESET_VAL, 0, value loaded into every register on reset.
- BYPASS, 1, 1 = read ports show the value being written this cycle; 0 = read ports show stored contents only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- in  input  WIDTH  write data.
- load  input  1  write in to entry waddr at next edge.
- inc  input  1  increment entry waddr at next edge (ignored when load=1).
- waddr  input  AW  write/increment address.
- clear  input  1  clear the written bitmap at next edge.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- out_a  output  WIDTH  read data, port A.
- out_b  output  WIDTH  read data, port B.
- written  output  DEPTH  bit i = entry i loaded or incremented since last reset/clear.

## Operation
- Storage: DEPTH×WIDTH flops, all updated only on the rising edge of clk.
- Per-edge priority, highest first:
  - rst_n=0: all entries <= RESET_VAL; written <= 0; load/inc/clear ignored.
  - load=1: entry[waddr] <= in.
  - inc=1: entry[waddr] <= entry[waddr]+1, modulo 2^WIDTH. All-ones wraps to 0 with no flag.
  - Otherwise: hold.
- waddr >= DEPTH: load/inc are no-ops; no entry changes and no written bit sets.
- Written bitmap:
  - written[waddr] <= 1 on any effective load or inc.
  - clear=1 zeroes all bits.
  - If clear and an effective load/inc occur in the same cycle, the result is exactly one-hot at waddr. Set wins over clear.
- Read ports are combinational and fully independent. raddr_a == raddr_b is legal, and both ports return identical data.
- raddr >= DEPTH reads 0.
- Bypass (BYPASS=1, rst_n=1, effective load or inc, raddr == waddr): the port shows the next value, i.e. in for load, entry+1 for inc.
- Bypass is disabled while rst_n=0.
- With BYPASS=0, the port shows stored contents and the new value appears after the edge.

## Timing
- Write latency: 1 cycle. The value presented at edge N is stored after edge N; stored reads reflect it from then on. With bypass, the value is visible combinationally in the same cycle as load.
- Read latency: 0 cycles (combinational from raddr and stored state).
- Reset:
  - One edge with rst_n=0 fully resets the bank.
  - After that edge, out_a = out_b = RESET_VAL for in-range addresses and written = 0.
  - Before the first reset edge, contents are undefined; the bench must reset first.
- Reset asserted mid-sequence (e.g. load held high): reset wins at that edge. Operation resumes at the first edge with rst_n=1.
- Back-to-back operations to the same entry on consecutive cycles are each applied in order. Example: load 5 then inc then inc yields 7.
- No multicycle paths. The bypass mux plus increment adder sits on the in→out and entry→out combinational paths, which must close at the Hack system clock.

## Test plan
- Reset, then read all 8 entries on both ports -> 0 everywhere, written=8'h00.
- load=1, waddr=3, in=2222, raddr_a=3, BYPASS=1 -> out_a=2222 in the same cycle. After the edge with load=0 and in=1111, out_a stays 2222 and written=8'h08. Repeat with BYPASS=0 -> out_a=0 before the edge, 2222 after.
- Load entry 5 with 16'hFFFE, then inc for 3 cycles -> out_b reads FFFF, 0000, 0001. A cycle with load=1, inc=1, in=7 -> entry 5 = 7 (load priority).
- Load entry 2 with 100 while clear=1 and written=8'h28 -> written=8'h04. Then clear alone -> 8'h00, and entry contents are unchanged.
- DEPTH=6: load waddr=7, in=9 -> no entry changes and written unchanged. raddr_a=7 -> out_a=0.
- Load entries 0..7 with i*11, then assert rst_n=0 for one edge while load=1, waddr=1, in=500 -> all entries 0, written=0. Deassert -> next load behaves normally.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register array with one write/increment port, two
// combinational read ports, optional write-through bypass and a bitmap of
// entries written since the last reset or clear.
module reg_bank #(
  parameter int unsigned          WIDTH     = 16,
  parameter int unsigned          DEPTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          BYPASS    = 1,
  localparam int unsigned         AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic [AW-1:0]    waddr,
  input  logic             clear,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [DEPTH-1:0] written
);

  // DEPTH need not be a power of two, so some addresses may point past the array.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DEPTH-1:0] written_d;

  logic             waddr_ok;
  logic             wr_en;
  logic [WIDTH-1:0] cur_w;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  // An out-of-range write address turns load/inc into a no-op everywhere,
  // including the bypass path and the written bitmap.
  assign wr_en    = (load || inc) && waddr_ok;

  // Look up the addressed entry and form the value that will be stored.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    cur_w = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (waddr == AW'(i)) cur_w = mem_q[i];
    end
    // Load has priority over increment; the adder wraps silently.
    next_val = load ? in : cur_w + WIDTH'(1);
  end

  // Next-state for the storage array and the written bitmap.
  always_comb begin
    mem_d     = mem_q;
    written_d = clear ? '0 : written_q;
    if (wr_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (waddr == AW'(i)) begin
          mem_d[i]     = next_val;
          // Setting after the clear makes set win over clear in the same cycle.
          written_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: each entry is reset explicitly because RESET_VAL must be readable after reset; this keeps the array in flops rather than RAM.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= RESET_VAL;
      written_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  // Read ports: stored contents (0 past DEPTH), overridden by the bypass value.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (raddr_a == AW'(i)) rd_a = mem_q[i];
      if (raddr_b == AW'(i)) rd_b = mem_q[i];
    end
    if ((BYPASS != 0) && rst_n && wr_en) begin
      if (raddr_a == waddr) rd_a = next_val;
      if (raddr_b == waddr) rd_b = next_val;
    end
  end

  assign out_a   = rd_a;
  assign out_b   = rd_b;
  assign written = written_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table-driven vectors plus hand sequences against three
// configurations sharing one stimulus bus; expectations go through a
// scoreboard queue and are compared on the falling edge.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;

  logic [15:0] out_a1, out_b1, out_a0, out_b0, out_a6, out_b6;
  logic [7:0]  wr1, wr0;
  logic [5:0]  wr6;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Main configuration: DEPTH=8, bypass on.
  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .inc(inc), .waddr(waddr),
    .clear(clear), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .out_a(out_a1), .out_b(out_b1), .written(wr1));

  // DEPTH=8, bypass off.
  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .inc(inc), .waddr(waddr),
    .clear(clear), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .out_a(out_a0), .out_b(out_b0), .written(wr0));

  // DEPTH=6 (non power of two), bypass on.
  reg_bank #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) u_d6 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .inc(inc), .waddr(waddr),
    .clear(clear), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .out_a(out_a6), .out_b(out_b6), .written(wr6));

  typedef struct {
    bit          rst_n, load, inc, clear;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic [2:0]  ra, rb;
    bit          chk;
    logic [15:0] ea, eb;
    logic [7:0]  ew;
  } vec_t;

  typedef struct {
    int          dut;
    string       tag;
    logic [15:0] ea, eb;
    logic [7:0]  ew;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[29];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(bit r, bit l, bit ic, bit cl, int wa, int d, int ra, int rb,
                             bit chk, int ea, int eb, int ew);
    vec_t t;
    t.rst_n = r;  t.load = l;  t.inc = ic;  t.clear = cl;
    t.waddr = 3'(wa);  t.din = 16'(d);  t.ra = 3'(ra);  t.rb = 3'(rb);
    t.chk = chk;  t.ea = 16'(ea);  t.eb = 16'(eb);  t.ew = 8'(ew);
    return t;
  endfunction

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(bit r, bit l, bit ic, bit cl, int wa, int d, int ra, int rb);
    @(posedge clk);
    #1;
    rst_n = r;  load = l;  inc = ic;  clear = cl;
    waddr = 3'(wa);  din = 16'(d);  raddr_a = 3'(ra);  raddr_b = 3'(rb);
  endtask

  task automatic expect_out(int dut, string tag, int ea, int eb, int ew);
    exp_t e;
    e.dut = dut;  e.tag = tag;  e.ea = 16'(ea);  e.eb = 16'(eb);  e.ew = 8'(ew);
    sb.push_back(e);
  endtask

  // Falling-edge sampler: pops every pending expectation and compares.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      exp_t e;
      logic [15:0] a, b, w;
      e = sb.pop_front();
      case (e.dut)
        0:       begin a = out_a1; b = out_b1; w = {8'h00, wr1}; end
        1:       begin a = out_a0; b = out_b0; w = {8'h00, wr0}; end
        default: begin a = out_a6; b = out_b6; w = {10'h000, wr6}; end
      endcase
      check({e.tag, ".out_a"}, a, e.ea);
      check({e.tag, ".out_b"}, b, e.eb);
      check({e.tag, ".written"}, w, {8'h00, e.ew});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst ld inc clr wa  din      ra rb chk ea       eb       ew
    tbl[0]  = v(0, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0,       8'h00);
    tbl[1]  = v(1, 0, 0, 0, 0, 0,       0, 1, 1, 0,       0,       8'h00);
    tbl[2]  = v(1, 0, 0, 0, 0, 0,       2, 3, 1, 0,       0,       8'h00);
    tbl[3]  = v(1, 0, 0, 0, 0, 0,       4, 5, 1, 0,       0,       8'h00);
    tbl[4]  = v(1, 0, 0, 0, 0, 0,       6, 7, 1, 0,       0,       8'h00);
    tbl[5]  = v(1, 1, 0, 0, 3, 2222,    3, 0, 1, 2222,    0,       8'h00);
    tbl[6]  = v(1, 0, 0, 0, 3, 1111,    3, 3, 1, 2222,    2222,    8'h08);
    tbl[7]  = v(1, 1, 0, 0, 5, 'hFFFE,  3, 5, 1, 2222,    'hFFFE,  8'h08);
    tbl[8]  = v(1, 0, 1, 0, 5, 0,       3, 5, 1, 2222,    'hFFFF,  8'h28);
    tbl[9]  = v(1, 0, 1, 0, 5, 0,       3, 5, 1, 2222,    'h0000,  8'h28);
    tbl[10] = v(1, 0, 1, 0, 5, 0,       3, 5, 1, 2222,    'h0001,  8'h28);
    tbl[11] = v(1, 1, 1, 0, 5, 7,       3, 5, 1, 2222,    7,       8'h28);
    tbl[12] = v(1, 0, 0, 0, 0, 0,       3, 5, 1, 2222,    7,       8'h28);
    tbl[13] = v(1, 1, 0, 1, 2, 100,     2, 5, 1, 100,     7,       8'h28);
    tbl[14] = v(1, 0, 0, 1, 0, 0,       2, 3, 1, 100,     2222,    8'h04);
    tbl[15] = v(1, 0, 0, 0, 0, 0,       5, 2, 1, 7,       100,     8'h00);
    for (int i = 0; i < 8; i++)
      tbl[16+i] = v(1, 1, 0, 0, i, i*11, i, i, 1, i*11, i*11, (1 << i) - 1);
    tbl[24] = v(0, 1, 0, 0, 1, 500,     1, 7, 1, 11,      77,      8'hFF);
    tbl[25] = v(1, 0, 0, 0, 0, 0,       1, 7, 1, 0,       0,       8'h00);
    tbl[26] = v(1, 0, 0, 0, 0, 0,       3, 5, 1, 0,       0,       8'h00);
    tbl[27] = v(1, 1, 0, 0, 1, 500,     1, 0, 1, 500,     0,       8'h00);
    tbl[28] = v(1, 0, 0, 0, 0, 0,       1, 1, 1, 500,     500,     8'h02);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rst_n, tbl[i].load, tbl[i].inc, tbl[i].clear,
            int'(tbl[i].waddr), int'(tbl[i].din), int'(tbl[i].ra), int'(tbl[i].rb));
      if (tbl[i].chk)
        expect_out(0, $sformatf("row%0d", i), int'(tbl[i].ea), int'(tbl[i].eb), int'(tbl[i].ew));
    end

    // Hand sequences: bypass-off visibility and out-of-range addressing on DEPTH=6.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 3, 2222, 3, 7);
    expect_out(1, "b0_load", 0, 0, 8'h00);
    expect_out(2, "d6_load", 2222, 0, 8'h00);
    drive(1, 0, 0, 0, 3, 1111, 3, 3);
    expect_out(1, "b0_after", 2222, 2222, 8'h08);
    expect_out(2, "d6_after", 2222, 2222, 8'h08);
    drive(1, 0, 1, 0, 3, 0, 3, 3);
    expect_out(1, "b0_inc", 2222, 2222, 8'h08);
    drive(1, 0, 0, 0, 0, 0, 3, 3);
    expect_out(1, "b0_inc_after", 2223, 2223, 8'h08);
    drive(1, 1, 0, 0, 7, 9, 7, 5);
    expect_out(2, "d6_load_oor", 0, 0, 8'h08);
    drive(1, 0, 1, 0, 6, 0, 6, 7);
    expect_out(2, "d6_inc_oor", 0, 0, 8'h08);
    drive(1, 0, 0, 0, 0, 0, 3, 6);
    expect_out(2, "d6_hold3", 2223, 0, 8'h08);
    drive(1, 0, 0, 0, 0, 0, 5, 4);
    expect_out(2, "d6_hold5", 0, 0, 8'h08);
    drive(1, 1, 0, 1, 5, 9, 5, 0);
    expect_out(2, "d6_load_clr", 9, 0, 8'h08);
    drive(1, 0, 0, 0, 0, 0, 5, 7);
    expect_out(2, "d6_onehot", 9, 0, 8'h20);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
